// File: rtl/load_unpack_ctrl.sv
// Load unpack controller: one aligned 64-bit read per load, then sign/zero-extends the addressed field.
// Latency: 3 cycles minimum from request acceptance to wb_valid.
// Backpressure: holds the memory request until mem_req_ready and the result until wb_ready; one load in flight.
package load_unpack_pkg;
  typedef logic [63:0] addr_t;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } mem_op_e;
endpackage

module load_unpack_ctrl
  import load_unpack_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_op_e     req_mem_op,
  input  addr_t       req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output addr_t       mem_raddr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        misalign_err,
  output logic        fault
);

  // Counter only needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  mem_op_e       op_q, op_d;
  addr_t         addr_q, addr_d;
  logic [4:0]    rd_q, rd_d;
  logic [63:0]   data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misalign_q, misalign_d;

  // Natural alignment: the access size must divide the byte address.
  function automatic logic is_misaligned(input mem_op_e op, input logic [2:0] lo);
    case (op)
      MEM_H, MEM_UH: is_misaligned = lo[0];
      MEM_W, MEM_UW: is_misaligned = |lo[1:0];
      MEM_D:         is_misaligned = |lo;
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

  // Shift the addressed byte lane down to bit 0, then extend to 64 bits.
  function automatic logic [63:0] extend(input mem_op_e op, input logic [2:0] lo,
                                         input logic [63:0] rdata);
    logic [63:0] x;
    x = rdata >> {lo, 3'b000};
    case (op)
      MEM_B:   extend = {{56{x[7]}}, x[7:0]};
      MEM_UB:  extend = {56'b0, x[7:0]};
      MEM_H:   extend = {{48{x[15]}}, x[15:0]};
      MEM_UH:  extend = {48'b0, x[15:0]};
      MEM_W:   extend = {{32{x[31]}}, x[31:0]};
      MEM_UW:  extend = {32'b0, x[31:0]};
      MEM_D:   extend = rdata;
      default: extend = '0;
    endcase
  endfunction

  // State and datapath registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      op_q       <= MEM_NO;
      addr_q     <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and output decode; outputs are only non-zero in the state that owns them.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    rd_d          = rd_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    misalign_d    = 1'b0;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_raddr     = '0;
    wb_valid      = 1'b0;
    wb_data       = '0;
    wb_rd         = '0;
    fault         = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d   = req_mem_op;
          addr_d = req_addr;
          rd_d   = req_rd;
          if (is_misaligned(req_mem_op, req_addr[2:0])) begin
            misalign_d = 1'b1;
          end else if (req_mem_op != MEM_NO) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_raddr     = {addr_q[63:3], 3'b000};
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          data_d  = extend(op_q, addr_q[2:0], mem_rdata);
          state_d = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        wb_valid = 1'b1;
        wb_data  = data_q;
        wb_rd    = rd_q;
        if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign misalign_err = misalign_q;

endmodule
